// File: rtl/mem_port_pkg.sv
// Shared limits and the byte-strobe merge helper for the mem_port_ram block.
package mem_port_pkg;

    // Legal range of read latency and read-port count
    localparam int RD_LAT_MIN  = 1;
    localparam int RD_LAT_MAX  = 8;
    localparam int N_RD_MAX    = 8;

    // Widest data word the merge helper handles; callers zero-extend into it
    localparam int MERGE_W_MAX = 1024;
    localparam int MERGE_B_MAX = MERGE_W_MAX / 8;

    // Returns old_w with every byte whose strobe bit is set replaced by new_w
    function automatic logic [MERGE_W_MAX-1:0] strb_merge(
        input logic [MERGE_W_MAX-1:0] old_w,
        input logic [MERGE_W_MAX-1:0] new_w,
        input logic [MERGE_B_MAX-1:0] strb
    );
        logic [MERGE_W_MAX-1:0] res;
        res = old_w;
        for (int b = 0; b < MERGE_B_MAX; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-result delay line: LATENCY stages of valid/data. A data stage only
// loads when the valid feeding it is set, so the last stage holds its value
// between results.
module mem_rd_pipe #(
    parameter int WIDTH   = 128,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;

    // Shift valid every cycle; advance data only alongside a valid
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        vld_d[0] = vld_i;
        if (vld_i) begin
            data_d[0] = data_i;
        end
        for (int s = 1; s < LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
            if (vld_q[s-1]) begin
                data_d[s] = data_q[s-1];
            end
        end
    end

    // Stage registers; reset drops anything in flight and zeroes the output
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q[LATENCY-1];
    assign data_o = data_q[LATENCY-1];

endmodule

// File: rtl/mem_port_ram.sv
// Multi-read, single-write word RAM with byte strobes, pipelined read ports,
// selectable read-during-write behaviour and a sticky out-of-range flag.
module mem_port_ram
    import mem_port_pkg::*;
#(
    parameter int N_RD       = 2,
    parameter int AXI_WIDTH  = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4096,
    parameter int RD_LATENCY = 1,
    parameter int RDW_NEW    = 0
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [N_RD-1:0]                     mm2s_ren,
    input  logic [N_RD-1:0][ADDR_WIDTH-1:0]     mm2s_addr,
    output logic [N_RD-1:0][AXI_WIDTH-1:0]      mm2s_data,
    output logic [N_RD-1:0]                     mm2s_rvalid,
    input  logic                                s2mm_wen,
    input  logic [ADDR_WIDTH-1:0]               s2mm_addr,
    input  logic [AXI_WIDTH-1:0]                s2mm_data,
    input  logic [AXI_WIDTH/8-1:0]              s2mm_strb,
    output logic                                err_oob
);

    localparam int NBYTES = AXI_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    // Parameter sanity: refuse to elaborate an impossible configuration
    if (AXI_WIDTH % 8 != 0) begin : g_bad_width
        $error("mem_port_ram: AXI_WIDTH must be a multiple of 8");
    end
    if (AXI_WIDTH > MERGE_W_MAX) begin : g_too_wide
        $error("mem_port_ram: AXI_WIDTH exceeds strobe-merge helper width");
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_WIDTH) || DEPTH < 1) begin : g_bad_depth
        $error("mem_port_ram: DEPTH must be 1..2**ADDR_WIDTH");
    end
    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
        $error("mem_port_ram: RD_LATENCY must be 1..8");
    end
    if (N_RD < 1 || N_RD > N_RD_MAX) begin : g_bad_nrd
        $error("mem_port_ram: N_RD must be 1..8");
    end

    logic [AXI_WIDTH-1:0]            mem_q [DEPTH];
    logic                            wr_in_rng;
    logic                            wr_ok;
    logic [IDX_W-1:0]                wr_idx;
    logic [N_RD-1:0]                 rd_in_rng;
    logic [N_RD-1:0][AXI_WIDTH-1:0]  rd_word_d;
    logic                            err_q, err_d;

    // Write qualification: in range, enabled, and not held in reset
    always_comb begin
        wr_in_rng = ({1'b0, s2mm_addr} < DEPTH_L);
        wr_ok     = rstn && s2mm_wen && wr_in_rng;
        wr_idx    = s2mm_addr[IDX_W-1:0];
    end

    // Byte-granular memory write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (s2mm_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= s2mm_data[8*b +: 8];
                end
            end
        end
    end

    // Per-port read word: zero when out of range, optionally forwarding a
    // same-cycle write to the same word as the strobe-merged result
    always_comb begin
        rd_in_rng = '0;
        rd_word_d = '0;
        for (int i = 0; i < N_RD; i++) begin
            rd_in_rng[i] = ({1'b0, mm2s_addr[i]} < DEPTH_L);
            if (rd_in_rng[i]) begin
                rd_word_d[i] = mem_q[mm2s_addr[i][IDX_W-1:0]];
                if (RDW_NEW != 0 && wr_ok && (s2mm_addr == mm2s_addr[i])) begin
                    rd_word_d[i] = AXI_WIDTH'(strb_merge(
                        MERGE_W_MAX'(mem_q[mm2s_addr[i][IDX_W-1:0]]),
                        MERGE_W_MAX'(s2mm_data),
                        MERGE_B_MAX'(s2mm_strb)));
                end
            end
        end
    end

    // One delay line per read port carries the result to the output
    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        mem_rd_pipe #(
            .WIDTH   (AXI_WIDTH),
            .LATENCY (RD_LATENCY)
        ) u_pipe (
            .clk    (clk),
            .rstn   (rstn),
            .vld_i  (mm2s_ren[g]),
            .data_i (rd_word_d[g]),
            .vld_o  (mm2s_rvalid[g]),
            .data_o (mm2s_data[g])
        );
    end

    // Out-of-range detection on any enabled access; sticky until reset
    always_comb begin
        err_d = err_q;
        if (s2mm_wen && !wr_in_rng) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < N_RD; i++) begin
            if (mm2s_ren[i] && !rd_in_rng[i]) begin
                err_d = 1'b1;
            end
        end
    end

    // Sticky error register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_oob = err_q;

endmodule

// File: tb/tb_mem_port_ram.sv
// Directed bench for mem_port_ram: three instances share one stimulus
// (A: latency 1 / old-data RDW, B: latency 3 / new-data RDW, C: latency 4 / old-data RDW).
module tb_mem_port_ram;

    localparam int AW    = 128;
    localparam int ADW   = 8;
    localparam int DEP   = 16;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int LAT_C = 4;

    localparam logic [AW-1:0] BYTES = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [AW-1:0] ONES  = {16{8'hFF}};
    localparam logic [AW-1:0] W7EXP = 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF;
    localparam logic [AW-1:0] V55   = {16{8'h55}};
    localparam logic [AW-1:0] VAA   = {16{8'hAA}};
    localparam logic [AW-1:0] V11   = {16{8'h11}};
    localparam logic [AW-1:0] V22   = {16{8'h22}};
    localparam logic [AW-1:0] V33   = {16{8'h33}};

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [1:0]            ren;
    logic [1:0][ADW-1:0]   raddr;
    logic                  wen;
    logic [ADW-1:0]        waddr;
    logic [AW-1:0]         wdata;
    logic [AW/8-1:0]       wstrb;

    logic [1:0][AW-1:0]    dat_a, dat_b, dat_c;
    logic [1:0]            rv_a, rv_b, rv_c;
    logic                  err_a, err_b, err_c;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_ram #(.N_RD(2), .AXI_WIDTH(AW), .ADDR_WIDTH(ADW), .DEPTH(DEP),
                   .RD_LATENCY(LAT_A), .RDW_NEW(0)) u_dut_a (
        .clk(clk), .rstn(rstn), .mm2s_ren(ren), .mm2s_addr(raddr),
        .mm2s_data(dat_a), .mm2s_rvalid(rv_a), .s2mm_wen(wen), .s2mm_addr(waddr),
        .s2mm_data(wdata), .s2mm_strb(wstrb), .err_oob(err_a));

    mem_port_ram #(.N_RD(2), .AXI_WIDTH(AW), .ADDR_WIDTH(ADW), .DEPTH(DEP),
                   .RD_LATENCY(LAT_B), .RDW_NEW(1)) u_dut_b (
        .clk(clk), .rstn(rstn), .mm2s_ren(ren), .mm2s_addr(raddr),
        .mm2s_data(dat_b), .mm2s_rvalid(rv_b), .s2mm_wen(wen), .s2mm_addr(waddr),
        .s2mm_data(wdata), .s2mm_strb(wstrb), .err_oob(err_b));

    mem_port_ram #(.N_RD(2), .AXI_WIDTH(AW), .ADDR_WIDTH(ADW), .DEPTH(DEP),
                   .RD_LATENCY(LAT_C), .RDW_NEW(0)) u_dut_c (
        .clk(clk), .rstn(rstn), .mm2s_ren(ren), .mm2s_addr(raddr),
        .mm2s_data(dat_c), .mm2s_rvalid(rv_c), .s2mm_wen(wen), .s2mm_addr(waddr),
        .s2mm_data(wdata), .s2mm_strb(wstrb), .err_oob(err_c));

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [ADW-1:0] a, input logic [AW-1:0] d,
                              input logic [AW/8-1:0] s);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    // One read on port p (optionally with a concurrent write and/or reset
    // release), then watch all three instances for five cycles.
    task automatic xfer(input string tag, input int p, input logic [ADW-1:0] ra,
                        input bit wr, input logic [ADW-1:0] wa, input logic [AW-1:0] wd,
                        input logic [AW/8-1:0] ws, input logic [AW-1:0] exp_old,
                        input logic [AW-1:0] exp_new, input bit rel);
        @(negedge clk);
        if (rel) rstn = 1'b1;
        ren = '0; ren[p] = 1'b1; raddr[p] = ra;
        wen = wr; waddr = wa; wdata = wd; wstrb = ws;
        @(posedge clk); #1;
        ren = '0; wen = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            chk($sformatf("%s_a_vld%0d", tag, k), AW'(rv_a[p]), AW'(k == LAT_A));
            chk($sformatf("%s_b_vld%0d", tag, k), AW'(rv_b[p]), AW'(k == LAT_B));
            chk($sformatf("%s_c_vld%0d", tag, k), AW'(rv_c[p]), AW'(k == LAT_C));
            if (k >= LAT_A) chk($sformatf("%s_a_dat%0d", tag, k), dat_a[p], exp_old);
            if (k >= LAT_B) chk($sformatf("%s_b_dat%0d", tag, k), dat_b[p], exp_new);
            if (k >= LAT_C) chk($sformatf("%s_c_dat%0d", tag, k), dat_c[p], exp_old);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rv_a"}, AW'(rv_a), '0);
        chk({tag, "_rv_b"}, AW'(rv_b), '0);
        chk({tag, "_rv_c"}, AW'(rv_c), '0);
        chk({tag, "_dat_a"}, dat_a[0] | dat_a[1], '0);
        chk({tag, "_dat_b"}, dat_b[0] | dat_b[1], '0);
        chk({tag, "_dat_c"}, dat_c[0] | dat_c[1], '0);
        chk({tag, "_err"}, AW'({err_a, err_b, err_c}), '0);
    endtask

    task automatic b2b_dut(input string nm, input int lat, input int c,
                           input logic [1:0] rv, input logic [1:0][AW-1:0] dat,
                           inout int cnt0, inout int cnt1);
        bit exp_v;
        exp_v = (c >= lat - 1) && (c <= lat + 14);
        chk($sformatf("b2b_%s_vld0_c%0d", nm, c), AW'(rv[0]), AW'(exp_v));
        chk($sformatf("b2b_%s_vld1_c%0d", nm, c), AW'(rv[1]), AW'(exp_v));
        if (exp_v) begin
            chk($sformatf("b2b_%s_dat0_c%0d", nm, c), dat[0], V11);
            chk($sformatf("b2b_%s_dat1_c%0d", nm, c), dat[1], V22);
        end
        cnt0 += int'(rv[0]);
        cnt1 += int'(rv[1]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ca0, ca1, cb0, cb1, cc0, cc1;
        rstn = 1'b0; ren = '0; raddr = '0; wen = 1'b0;
        waddr = '0; wdata = '0; wstrb = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("rst");
        @(negedge clk);
        rstn = 1'b1;

        // Full-word write then read, latency per instance
        write_word(8'd5, BYTES, 16'hFFFF);
        xfer("rd5", 0, 8'd5, 1'b0, '0, '0, '0, BYTES, BYTES, 1'b0);

        // Partial strobe write
        write_word(8'd7, ONES, 16'hFFFF);
        write_word(8'd7, '0, 16'h00F0);
        xfer("strb", 1, 8'd7, 1'b0, '0, '0, '0, W7EXP, W7EXP, 1'b0);

        // Zero strobe is a no-op
        write_word(8'd5, ONES, 16'h0000);
        xfer("strb0", 0, 8'd5, 1'b0, '0, '0, '0, BYTES, BYTES, 1'b0);

        // Read-during-write to the same word
        write_word(8'd3, V55, 16'hFFFF);
        xfer("rdw", 0, 8'd3, 1'b1, 8'd3, VAA, 16'hFFFF, V55, VAA, 1'b0);
        xfer("rdw_after", 1, 8'd3, 1'b0, '0, '0, '0, VAA, VAA, 1'b0);

        // Back-to-back reads on both ports
        write_word(8'd1, V11, 16'hFFFF);
        write_word(8'd2, V22, 16'hFFFF);
        ca0 = 0; ca1 = 0; cb0 = 0; cb1 = 0; cc0 = 0; cc1 = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ren = (c < 16) ? 2'b11 : 2'b00;
            raddr[0] = 8'd1; raddr[1] = 8'd2;
            @(posedge clk); #1;
            b2b_dut("a", LAT_A, c, rv_a, dat_a, ca0, ca1);
            b2b_dut("b", LAT_B, c, rv_b, dat_b, cb0, cb1);
            b2b_dut("c", LAT_C, c, rv_c, dat_c, cc0, cc1);
        end
        ren = '0;
        chk("b2b_cnt_a0", AW'(ca0), 128'd16); chk("b2b_cnt_a1", AW'(ca1), 128'd16);
        chk("b2b_cnt_b0", AW'(cb0), 128'd16); chk("b2b_cnt_b1", AW'(cb1), 128'd16);
        chk("b2b_cnt_c0", AW'(cc0), 128'd16); chk("b2b_cnt_c1", AW'(cc1), 128'd16);

        // Out-of-range read and write
        chk("oob_err_pre", AW'({err_a, err_b, err_c}), 128'd0);
        xfer("oob_rd", 0, 8'(DEP), 1'b0, '0, '0, '0, '0, '0, 1'b0);
        chk("oob_err_set", AW'({err_a, err_b, err_c}), 128'd7);
        write_word(8'(DEP + 1), VAA, 16'hFFFF);
        xfer("oob_wr", 1, 8'd1, 1'b0, '0, '0, '0, V11, V11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("oob_err_sticky", AW'({err_a, err_b, err_c}), 128'd7);

        // Reset with reads in flight; writes during reset ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ren = 2'b01; raddr[0] = 8'd1;
            @(posedge clk);
        end
        @(negedge clk);
        ren = '0; rstn = 1'b0;
        wen = 1'b1; waddr = 8'd2; wdata = V33; wstrb = 16'hFFFF;
        @(posedge clk); #1;
        chk_quiet("inrst0");
        @(posedge clk); #1;
        chk_quiet("inrst1");
        @(negedge clk);
        rstn = 1'b1; wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk_quiet($sformatf("postrst%0d", i));
        end
        xfer("rst_wr_ign", 1, 8'd2, 1'b0, '0, '0, '0, V22, V22, 1'b0);

        // First read on the release edge completes normally
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        xfer("rel_rd", 0, 8'd1, 1'b0, '0, '0, '0, V11, V11, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
